// File: rtl/median_pkg.sv
// Shared constants and types for the median filter input path.
package median_pkg;
  localparam int unsigned DEFAULT_WIDTH    = 32;
  localparam int unsigned DEFAULT_LINE_LEN = 8;
  localparam int unsigned ROW_DEPTH        = 2;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } feeder_state_e;
endpackage

// File: rtl/median_line_buffer.sv
// One row of pixel storage: combinational read and synchronous write at the same column.
module median_line_buffer
  import median_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned LINE_LEN = DEFAULT_LINE_LEN,
  parameter int unsigned CNT_W    = $clog2(LINE_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [CNT_W-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [LINE_LEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/median_window_feeder.sv
// Buffers two previous rows of a raster stream and emits vertically aligned
// three-pixel columns (rows n-2, n-1, n) to the median filter.
module median_window_feeder
  import median_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned LINE_LEN = DEFAULT_LINE_LEN,
  parameter int unsigned CNT_W    = $clog2(LINE_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic             out_last
);

  feeder_state_e    state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [1:0]       rows_q, rows_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] out0_q, out0_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic [WIDTH-1:0] lb0_rdata, lb1_rdata;
  logic             accept;
  logic             col_last;

  // rst_n gates in_ready so the source sees "not ready" during reset.
  assign in_ready = rst_n && !clear && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign col_last = (col_q == CNT_W'(LINE_LEN - 1));

  median_line_buffer #(.WIDTH(WIDTH), .LINE_LEN(LINE_LEN), .CNT_W(CNT_W)) u_lb0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .addr  (col_q),
    .wdata (lb1_rdata),
    .rdata (lb0_rdata)
  );

  median_line_buffer #(.WIDTH(WIDTH), .LINE_LEN(LINE_LEN), .CNT_W(CNT_W)) u_lb1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .addr  (col_q),
    .wdata (in_data),
    .rdata (lb1_rdata)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    rows_d      = rows_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out0_d      = out0_q;
    out1_d      = out1_q;
    out2_d      = out2_q;
    if (clear) begin
      state_d     = FILL;
      col_d       = '0;
      rows_d      = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      if (accept) begin
        col_d = col_last ? '0 : col_q + CNT_W'(1);
        if (col_last && rows_q != 2'(ROW_DEPTH)) begin
          rows_d = rows_q + 2'd1;
        end
        if (col_last && rows_q == 2'(ROW_DEPTH - 1)) begin
          state_d = STREAM;
        end
      end
      // The wrapping accept in FILL is not emitted: state_q is still FILL here.
      if (accept && state_q == STREAM) begin
        out0_d      = lb0_rdata;
        out1_d      = lb1_rdata;
        out2_d      = in_data;
        out_last_d  = col_last;
        out_valid_d = 1'b1;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      col_q       <= '0;
      rows_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
      out2_q      <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      rows_q      <= rows_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out2_q      <= out2_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out0_data = out0_q;
  assign out1_data = out1_q;
  assign out2_data = out2_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Bench for median_window_feeder: frame-queue reference model plus directed literal checks.
module tb_median_window_feeder;
  localparam int unsigned W = 32;
  localparam int unsigned L = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out0_data, out1_data, out2_data;
  logic         out_last;

  int checks = 0;
  int errors = 0;

  median_window_feeder #(.WIDTH(W), .LINE_LEN(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0_data (out0_data),
    .out1_data (out1_data),
    .out2_data (out2_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Reference: every word accepted since frame start is kept; pixel p (p >= 2L)
  // produces column (p-2L, p-L, p).
  logic [W-1:0] frame[$];
  logic         exp_valid = 1'b0;
  logic         exp_last  = 1'b0;
  logic [W-1:0] exp0 = '0, exp1 = '0, exp2 = '0;

  function automatic logic exp_ready();
    return rst_n && !clear && (!exp_valid || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame.delete();
      exp_valid = 1'b0;
      exp_last  = 1'b0;
      exp0 = '0; exp1 = '0; exp2 = '0;
    end else begin
      logic acc;
      int   p;
      acc = in_valid && exp_ready();
      if (clear) begin
        frame.delete();
        exp_valid = 1'b0;
        exp_last  = 1'b0;
      end else begin
        p = -1;
        if (acc) begin
          frame.push_back(in_data);
          p = frame.size() - 1;
        end
        if (acc && p >= 2 * L) begin
          exp0 = frame[p - 2 * L];
          exp1 = frame[p - L];
          exp2 = frame[p];
          exp_last  = ((p % L) == L - 1);
          exp_valid = 1'b1;
        end else if (out_ready) begin
          exp_valid = 1'b0;
        end
      end
    end
  end

  task automatic cmp(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    cmp("model_in_ready", W'(in_ready), W'(exp_ready()));
    cmp("model_out_valid", W'(out_valid), W'(exp_valid));
    cmp("model_out_last", W'(out_last), W'(exp_last));
    cmp("model_out0", out0_data, exp0);
    cmp("model_out1", out1_data, exp1);
    cmp("model_out2", out2_data, exp2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_col(input string name, input int a, input int b, input int c, input logic last);
    cmp({name, "_valid"}, W'(out_valid), W'(1));
    cmp({name, "_out0"}, out0_data, W'(a));
    cmp({name, "_out1"}, out1_data, W'(b));
    cmp({name, "_out2"}, out2_data, W'(c));
    cmp({name, "_last"}, W'(out_last), W'(last));
  endtask

  initial begin
    int nvalid;

    // Reset and idle
    repeat (3) begin
      tick();
      cmp("rst_in_ready_low", W'(in_ready), W'(0));
      cmp("rst_out_valid", W'(out_valid), W'(0));
      cmp("rst_out2", out2_data, W'(0));
    end
    rst_n = 1'b1;
    tick();
    cmp("post_rst_in_ready", W'(in_ready), W'(1));
    cmp("post_rst_out_valid", W'(out_valid), W'(0));
    cmp("post_rst_out0", out0_data, W'(0));

    // Fill then stream, and row scrolling
    nvalid = 0;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      tick();
      if (i < 24 && out_valid) nvalid++;
      if (i < 16) cmp("fill_no_valid", W'(out_valid), W'(0));
      if (i == 16) chk_col("first_col", 0, 8, 16, 1'b0);
      if (i == 23) chk_col("row2_last", 7, 15, 23, 1'b1);
      if (i >= 24) chk_col("row3_scroll", i - 16, i - 8, i, (i == 31));
    end
    cmp("row2_output_count", W'(nvalid), W'(8));

    // Backpressure
    in_data = W'(32);
    tick();
    chk_col("bp_before", 16, 24, 32, 1'b0);
    out_ready = 1'b0;
    in_data   = W'(33);
    #1;
    cmp("bp_in_ready", W'(in_ready), W'(0));
    repeat (4) begin
      tick();
      chk_col("bp_hold", 16, 24, 32, 1'b0);
      cmp("bp_hold_in_ready", W'(in_ready), W'(0));
    end
    out_ready = 1'b1;
    tick();
    chk_col("bp_resume", 17, 25, 33, 1'b0);
    in_data = W'(34);
    tick();
    chk_col("bp_next", 18, 26, 34, 1'b0);

    // clear mid-row
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = W'(100 + i);
      tick();
    end
    chk_col("pre_clear", 103, 111, 119, 1'b0);
    clear   = 1'b1;
    in_data = W'(999);
    #1;
    cmp("clear_in_ready", W'(in_ready), W'(0));
    tick();
    cmp("clear_out_valid", W'(out_valid), W'(0));
    cmp("clear_out_last", W'(out_last), W'(0));
    clear = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_data = W'(200 + i);
      tick();
      if (i < 16) cmp("clear_refill_no_valid", W'(out_valid), W'(0));
    end
    chk_col("clear_new_frame", 200, 208, 216, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 199) == 0);
      in_data   = $urandom;
      tick();
    end

    // Async reset mid-stream
    clear     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = W'(300 + i);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    chk_col("pre_async_rst", 300, 308, 316, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_rst_valid", W'(out_valid), W'(0));
    cmp("async_rst_out0", out0_data, W'(0));
    cmp("async_rst_out1", out1_data, W'(0));
    cmp("async_rst_out2", out2_data, W'(0));
    cmp("async_rst_in_ready", W'(in_ready), W'(0));
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = W'(400 + i);
      tick();
      if (i < 16) cmp("post_async_no_valid", W'(out_valid), W'(0));
    end
    chk_col("post_async_first", 400, 408, 416, 1'b0);
    in_valid = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
